// File: rtl/branch_pc_unit_if.sv
// Bus bundle for the branch/PC stage: PC load, branch request
// and the resolved-branch results.
interface branch_pc_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             pc_write;
  logic [WIDTH-1:0] pc_next_in;
  logic             start;
  logic [1:0]       br_type;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [15:0]      offset;
  logic [WIDTH-1:0] pc_out;
  logic             busy;
  logic             done;
  logic             taken;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output pc_write, pc_next_in, start,
    output br_type, rs_val, rt_val, offset,
    input  pc_out, busy, done, taken, taken_cnt
  );

  modport slave (
    input  pc_write, pc_next_in, start,
    input  br_type, rs_val, rt_val, offset,
    output pc_out, busy, done, taken, taken_cnt
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Multicycle branch resolution and PC register:
// IDLE -> CMP -> DECIDE -> UPDATE, all outputs registered.
module branch_pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 16
) (
  input logic             clk,
  input logic             reset_n,
  branch_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_DECIDE,
    S_UPDATE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] rt_q, rt_d;
  logic [15:0]      off_q, off_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             cond_q, cond_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] off_ext;

  // word offset -> byte offset, sign-extended to the PC width
  assign off_ext = {{(WIDTH-18){off_q[15]}}, off_q, 2'b00};

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    off_d   = off_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    cond_d  = cond_q;
    tgt_d   = tgt_q;
    pc_d    = pc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    taken_d = taken_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          type_d  = bus.br_type;
          rs_d    = bus.rs_val;
          rt_d    = bus.rt_val;
          off_d   = bus.offset;
          busy_d  = 1'b1;
          state_d = S_CMP;
        end else if (bus.pc_write) begin
          pc_d = bus.pc_next_in;
        end
      end
      S_CMP: begin
        eq_d    = (rs_q == rt_q);
        gt_d    = ($signed(rs_q) > $signed(rt_q));
        state_d = S_DECIDE;
      end
      S_DECIDE: begin
        unique case (type_q)
          2'b00: cond_d = eq_q;
          2'b01: cond_d = !eq_q;
          2'b10: cond_d = !gt_q;
          2'b11: cond_d = gt_q;
        endcase
        tgt_d   = pc_q + off_ext;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (cond_q) begin
          pc_d = tgt_q;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        taken_d = cond_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      off_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      cond_q  <= 1'b0;
      tgt_q   <= '0;
      pc_q    <= RESET_PC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      off_q   <= off_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      cond_q  <= cond_d;
      tgt_q   <= tgt_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.taken     = taken_q;
  assign bus.taken_cnt = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Random and directed bench for branch_pc_unit against
// an arithmetic reference model of PC, taken flag and counter.
module tb_branch_pc_unit;
  localparam int W  = 32;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;

  bit [31:0] m_pc = '0;
  int        m_cnt = 0;
  bit        m_taken = 1'b0;

  branch_pc_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  branch_pc_unit #(
    .WIDTH(W),
    .RESET_PC('0),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_cond(bit [1:0] t, bit [31:0] a, bit [31:0] b);
    int sa = a;
    int sb = b;
    case (t)
      2'd0:    return sa == sb;
      2'd1:    return sa != sb;
      2'd2:    return !(sa > sb);
      default: return sa > sb;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_cnt = 0;
    m_taken = 1'b0;
  endtask

  task automatic set_pc(bit [31:0] v);
    @(negedge clk);
    bus.pc_write = 1'b1;
    bus.pc_next_in = v;
    @(posedge clk);
    #1;
    bus.pc_write = 1'b0;
    m_pc = v;
    chk("pc_write", bus.pc_out, m_pc);
  endtask

  task automatic branch(bit [1:0] t, bit [31:0] a, bit [31:0] b,
                        bit [15:0] off, bit collide, bit noisy);
    bit        c;
    int        so;
    int        n;
    bit [31:0] tgt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.br_type = t;
    bus.rs_val = a;
    bus.rt_val = b;
    bus.offset = off;
    if (collide) begin
      bus.pc_write = 1'b1;
      bus.pc_next_in = $urandom;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.pc_write = 1'b0;
    chk("busy_start", bus.busy, 1);
    chk("pc_hold_start", bus.pc_out, m_pc);
    n = 0;
    while (n < 8) begin
      if (noisy) begin
        bus.start = 1'b1;
        bus.pc_write = 1'b1;
        bus.pc_next_in = $urandom;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        bus.offset = 16'($urandom);
        bus.br_type = 2'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
      bus.start = 1'b0;
      bus.pc_write = 1'b0;
      if (bus.done) break;
      chk("busy_mid", bus.busy, 1);
    end
    chk("latency", 64'(n), 64'd3);
    so = $signed(off);
    c = ref_cond(t, a, b);
    tgt = m_pc + 32'(so * 4);
    if (c) begin
      m_pc = tgt;
      if (m_cnt < CMAX) m_cnt++;
    end
    m_taken = c;
    chk("pc", bus.pc_out, m_pc);
    chk("taken", bus.taken, m_taken);
    chk("cnt", bus.taken_cnt, 64'(m_cnt));
    chk("busy_done", bus.busy, 0);
    @(posedge clk);
    #1;
    chk("done_pulse", bus.done, 0);
    chk("taken_hold", bus.taken, m_taken);
  endtask

  initial begin
    bit [31:0] a;
    bit [31:0] b;
    bus.pc_write = 1'b0;
    bus.pc_next_in = '0;
    bus.start = 1'b0;
    bus.br_type = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.offset = '0;

    #12;
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_taken", bus.taken, 0);
    chk("rst_cnt", bus.taken_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;

    set_pc(32'h100);
    branch(2'd0, 32'd5, 32'd5, 16'd3, 1'b0, 1'b0);
    chk("t2_pc", bus.pc_out, 32'h10C);
    chk("t2_cnt", bus.taken_cnt, 1);

    branch(2'd1, 32'd7, 32'd7, 16'd9, 1'b0, 1'b0);
    chk("t3_bne", bus.pc_out, 32'h10C);
    branch(2'd2, 32'd1, 32'hFFFF_FFFF, 16'd9, 1'b0, 1'b0);
    chk("t3_ble", bus.taken, 0);

    set_pc(32'h200);
    branch(2'd3, -32'sd2, -32'sd5, 16'hFFFF, 1'b0, 1'b0);
    chk("t4_bgt", bus.pc_out, 32'h1FC);
    branch(2'd3, 32'h7FFF_FFFF, 32'h8000_0000, 16'd1, 1'b0, 1'b0);
    chk("t4_extreme", bus.taken, 1);

    set_pc(32'hFFFF_FFFC);
    branch(2'd0, 32'd9, 32'd9, 16'd1, 1'b0, 1'b0);
    chk("t5_wrap", bus.pc_out, 0);

    branch(2'd1, 32'd1, 32'd2, 16'd4, 1'b1, 1'b0);
    branch(2'd0, 32'd3, 32'd3, 16'h8000, 1'b0, 1'b1);

    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) set_pc($urandom);
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) - 32'd4
                                      : $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom_range(0, 8)) - 32'd4;
      branch(2'($urandom), a, b, 16'($urandom),
             1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < CMAX + 4; i++) begin
      branch(2'd0, 32'd1, 32'd1, 16'($urandom), 1'b0, 1'b0);
    end
    chk("t5_sat", bus.taken_cnt, CMAX);

    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("t1_async_pc", bus.pc_out, 0);
    chk("t1_async_busy", bus.busy, 0);
    chk("t1_async_cnt", bus.taken_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;

    set_pc(32'h40);
    branch(2'd0, 32'd2, 32'd2, 16'd1, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.br_type = 2'd0;
    bus.rs_val = 32'd6;
    bus.rt_val = 32'd6;
    bus.offset = 16'd8;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_pc", bus.pc_out, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_cnt", bus.taken_cnt, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("t6_no_done", bus.done, 0);
      chk("t6_pc_idle", bus.pc_out, 0);
    end
    branch(2'd3, 32'd9, 32'd2, 16'd5, 1'b0, 1'b0);
    chk("t6_after", bus.pc_out, 32'h14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
